// File: rtl/regressor_pkg.sv
// Shared constants, FSM state type and run-length clamp for the regressor driver.
package regressor_pkg;

  localparam int DW    = 20;
  localparam int DEPTH = 150;
  localparam int AW    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  // A zero or oversized run length means "stream the whole memory".
  function automatic logic [AW-1:0] clamp_n(input logic [AW-1:0] n);
    if (n == '0 || n > AW'(DEPTH)) return AW'(DEPTH);
    return n;
  endfunction

endpackage

// File: rtl/regressor_sample_mem.sv
// Sample store: parallel x/y register arrays, one write port that drops
// out-of-range addresses, one combinational read port.
module regressor_sample_mem #(
  parameter int DW    = regressor_pkg::DW,
  parameter int DEPTH = regressor_pkg::DEPTH,
  parameter int AW    = regressor_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wx,
  input  logic [DW-1:0] wy,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rx,
  output logic [DW-1:0] ry
);

  localparam logic [AW-1:0] LP_DEPTH = AW'(DEPTH);

  logic [DW-1:0] r_x [DEPTH];
  logic [DW-1:0] r_y [DEPTH];

  always_ff @(posedge clk) begin
    if (we && waddr < LP_DEPTH) begin
      r_x[waddr] <= wx;
      r_y[waddr] <= wy;
    end
  end

  // The streaming index briefly reaches N (possibly DEPTH); read zero there.
  assign rx = (raddr < LP_DEPTH) ? r_x[raddr] : '0;
  assign ry = (raddr < LP_DEPTH) ? r_y[raddr] : '0;

endmodule

// File: rtl/regressor_driver.sv
// Sequencer that streams stored samples into the regressor and captures its results.
// Optional WAIT watchdog and sticky timeout flag: define REGRESSOR_DRIVER_TIMEOUT_EN.
module regressor_driver #(
  parameter int DW    = regressor_pkg::DW,
  parameter int DEPTH = regressor_pkg::DEPTH,
  parameter int AW    = regressor_pkg::AW
`ifdef REGRESSOR_DRIVER_TIMEOUT_EN
  , parameter int TIMEOUT = 4096
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_we,
  input  logic [AW-1:0]         load_addr,
  input  logic [DW-1:0]         load_x,
  input  logic [DW-1:0]         load_y,
  input  logic [AW-1:0]         n_samples,
  input  logic                  go,
  output logic [DW-1:0]         xi,
  output logic [DW-1:0]         yi,
  output logic                  s,
  input  logic                  ready,
  input  logic [DW-1:0]         error,
  input  logic [DW-1:0]         b0,
  input  logic [DW-1:0]         b1,
  output logic                  busy,
  output logic                  done,
  output logic [DW-1:0]         b0_q,
  output logic [DW-1:0]         b1_q,
  output logic [DW-1:0]         err_q,
`ifdef REGRESSOR_DRIVER_TIMEOUT_EN
  output logic                  timeout,
`endif
  output regressor_pkg::state_t dbg_state
);
  import regressor_pkg::*;

  // Handshake: s is a one-cycle start strobe; samples follow on consecutive
  // cycles with no backpressure; ready is sampled only in WAIT, and one cycle
  // of ready completes the transfer of b0/b1/error.

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_n;
  logic          w_we;
  logic [DW-1:0] w_rd_x;
  logic [DW-1:0] w_rd_y;

`ifdef REGRESSOR_DRIVER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wd;
`endif

  assign w_we      = load_we && (r_state == S_IDLE || r_state == S_DONE);
  assign dbg_state = r_state;

  regressor_sample_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (load_addr),
    .wx    (load_x),
    .wy    (load_y),
    .raddr (r_idx),
    .rx    (w_rd_x),
    .ry    (w_rd_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_n     <= '0;
      xi      <= '0;
      yi      <= '0;
      s       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
      err_q   <= '0;
`ifdef REGRESSOR_DRIVER_TIMEOUT_EN
      r_wd    <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_n     <= clamp_n(n_samples);
            r_idx   <= '0;
            s       <= 1'b1;
            busy    <= 1'b1;
            xi      <= '0;
            yi      <= '0;
            r_state <= S_START;
`ifdef REGRESSOR_DRIVER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        S_START: begin
          s       <= 1'b0;
          xi      <= w_rd_x;
          yi      <= w_rd_y;
          r_idx   <= r_idx + 1'b1;
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          // idx == N means the last sample is already on the bus.
          if (r_idx == r_n) begin
            xi      <= '0;
            yi      <= '0;
            r_state <= S_WAIT;
`ifdef REGRESSOR_DRIVER_TIMEOUT_EN
            r_wd    <= '0;
`endif
          end else begin
            xi    <= w_rd_x;
            yi    <= w_rd_y;
            r_idx <= r_idx + 1'b1;
          end
        end
        S_WAIT: begin
          if (ready) begin
            b0_q    <= b0;
            b1_q    <= b1;
            err_q   <= error;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
`ifdef REGRESSOR_DRIVER_TIMEOUT_EN
          else if (r_wd == CW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
